// File: rtl/vga_timing_stream_if.sv
// rtl/vga_timing_stream_if.sv - show-ahead FIFO read port between the pixel source and the display engine
interface vga_timing_stream_if #(
  parameter int DATA_WIDTH = 24
);
  logic [DATA_WIDTH-1:0] pix_data;
  logic                  pix_valid;
  logic                  pix_ready;

  modport master (
    output pix_data,
    output pix_valid,
    input  pix_ready
  );

  modport slave (
    input  pix_data,
    input  pix_valid,
    output pix_ready
  );
endinterface

// File: rtl/vga_timing_stream.sv
// rtl/vga_timing_stream.sv - parametrised VGA timing engine pulling pixels from a show-ahead FIFO
// Starts on a synchronised "FIFO primed" flag, flags underflow, and stops only at a frame boundary.
module vga_timing_stream #(
  parameter int HDISP      = 800,
  parameter int VDISP      = 480,
  parameter int HFP        = 40,
  parameter int HPULSE     = 48,
  parameter int HBP        = 40,
  parameter int VFP        = 13,
  parameter int VPULSE     = 3,
  parameter int VBP        = 29,
  parameter bit HS_POL     = 1'b0,
  parameter bit VS_POL     = 1'b0,
  parameter int DATA_WIDTH = 24,
  parameter logic [DATA_WIDTH-1:0] UNDERFLOW_COLOR = 24'hFF00FF,
  localparam int HBLANK    = HFP + HPULSE + HBP,
  localparam int VBLANK    = VFP + VPULSE + VBP,
  localparam int HTOTAL    = HDISP + HBLANK,
  localparam int VTOTAL    = VDISP + VBLANK,
  localparam int HW        = $clog2(HTOTAL),
  localparam int VW        = $clog2(VTOTAL)
) (
  input  logic                  pixel_clk,
  input  logic                  pixel_rst,
  input  logic                  enable,
  input  logic                  pix_start,
  vga_timing_stream_if.slave    pix,
  input  logic                  underflow_clr,
  output logic                  hs,
  output logic                  vs,
  output logic                  blank,
  output logic [DATA_WIDTH-1:0] rgb,
  output logic [HW-1:0]         x,
  output logic [VW-1:0]         y,
  output logic                  frame_start,
  output logic                  underflow,
  output logic [15:0]           underflow_count
);

  localparam logic [HW-1:0] H_LAST      = HW'(HTOTAL - 1);
  localparam logic [HW-1:0] H_SYNC_BEG  = HW'(HFP);
  localparam logic [HW-1:0] H_SYNC_END  = HW'(HFP + HPULSE);
  localparam logic [HW-1:0] H_ACT_BEG   = HW'(HBLANK);
  localparam logic [VW-1:0] V_LAST      = VW'(VTOTAL - 1);
  localparam logic [VW-1:0] V_SYNC_BEG  = VW'(VFP);
  localparam logic [VW-1:0] V_SYNC_END  = VW'(VFP + VPULSE);
  localparam logic [VW-1:0] V_ACT_BEG   = VW'(VBLANK);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;

  logic start_meta_q;
  logic start_s_q;

  logic                  hs_q;
  logic                  vs_q;
  logic                  blank_q;
  logic [DATA_WIDTH-1:0] rgb_q;
  logic [HW-1:0]         x_q;
  logic [VW-1:0]         y_q;
  logic                  frame_start_q;
  logic                  underflow_q;
  logic [15:0]           underflow_count_q;

  logic running;
  logic h_wrap;
  logic v_wrap;
  logic frame_end;
  logic active;
  logic hs_on;
  logic vs_on;
  logic underflow_now;

  // pix_start comes from the FIFO write domain
  always_ff @(posedge pixel_clk or posedge pixel_rst) begin
    if (pixel_rst) begin
      start_meta_q <= 1'b0;
      start_s_q    <= 1'b0;
    end else begin
      start_meta_q <= pix_start;
      start_s_q    <= start_meta_q;
    end
  end

  assign running       = (state_q != ST_IDLE);
  assign h_wrap        = (h_q == H_LAST);
  assign v_wrap        = (v_q == V_LAST);
  assign frame_end     = h_wrap && v_wrap;
  assign active        = running && (h_q >= H_ACT_BEG) && (v_q >= V_ACT_BEG);
  assign hs_on         = running && (h_q >= H_SYNC_BEG) && (h_q < H_SYNC_END);
  assign vs_on         = running && (v_q >= V_SYNC_BEG) && (v_q < V_SYNC_END);
  assign underflow_now = active && !pix.pix_valid;

  assign pix.pix_ready = active;

  always_ff @(posedge pixel_clk or posedge pixel_rst) begin
    if (pixel_rst) begin
      state_q <= ST_IDLE;
      h_q     <= '0;
      v_q     <= '0;
    end else begin
      state_q <= state_d;
      h_q     <= h_d;
      v_q     <= v_d;
    end
  end

  // Re-enabling while draining resumes without a gap; the frame keeps its phase
  always_comb begin
    state_d = state_q;
    h_d     = h_q;
    v_d     = v_q;
    unique case (state_q)
      ST_IDLE: begin
        if (enable && start_s_q) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (!enable) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (enable) begin
          state_d = ST_RUN;
        end else if (frame_end) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (running) begin
      if (h_wrap) begin
        h_d = '0;
        v_d = v_wrap ? '0 : v_q + 1'b1;
      end else begin
        h_d = h_q + 1'b1;
      end
    end else begin
      h_d = '0;
      v_d = '0;
    end
  end

  always_ff @(posedge pixel_clk or posedge pixel_rst) begin
    if (pixel_rst) begin
      hs_q          <= ~HS_POL;
      vs_q          <= ~VS_POL;
      blank_q       <= 1'b0;
      rgb_q         <= '0;
      x_q           <= '0;
      y_q           <= '0;
      frame_start_q <= 1'b0;
    end else begin
      hs_q          <= hs_on ? HS_POL : ~HS_POL;
      vs_q          <= vs_on ? VS_POL : ~VS_POL;
      blank_q       <= active;
      rgb_q         <= active ? (pix.pix_valid ? pix.pix_data : UNDERFLOW_COLOR) : '0;
      x_q           <= active ? (h_q - H_ACT_BEG) : '0;
      y_q           <= active ? (v_q - V_ACT_BEG) : '0;
      frame_start_q <= running && (h_q == '0) && (v_q == '0);
    end
  end

  // A new underflow outranks a simultaneous clear; the count only resets with pixel_rst
  always_ff @(posedge pixel_clk or posedge pixel_rst) begin
    if (pixel_rst) begin
      underflow_q       <= 1'b0;
      underflow_count_q <= '0;
    end else begin
      if (underflow_now) begin
        underflow_q <= 1'b1;
      end else if (underflow_clr) begin
        underflow_q <= 1'b0;
      end
      if (underflow_now && (underflow_count_q != 16'hFFFF)) begin
        underflow_count_q <= underflow_count_q + 16'd1;
      end
    end
  end

  assign hs              = hs_q;
  assign vs              = vs_q;
  assign blank           = blank_q;
  assign rgb             = rgb_q;
  assign x               = x_q;
  assign y               = y_q;
  assign frame_start     = frame_start_q;
  assign underflow       = underflow_q;
  assign underflow_count = underflow_count_q;

endmodule
